// File: rtl/left_shift_sequencer.sv
// Iterative left shifter / rotator: one bit position per clock, start/ready handshake,
// one-cycle done pulse with sticky overflow and last-bit-out reporting.
module left_shift_sequencer #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] amt,
  output logic               ready,
  output logic               done,
  output logic [WIDTH-1:0]   out,
  output logic               overflow,
  output logic               carry_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_mode;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_out;
  logic               r_overflow;
  logic               r_carry;

  logic               w_fill;
  logic               w_msb;
  logic [WIDTH-1:0]   w_workNext;
  logic               w_ovfNext;
  logic               w_lastShift;

  assign w_msb       = r_work[WIDTH-1];
  assign w_fill      = r_mode & w_msb;
  assign w_workNext  = {r_work[WIDTH-2:0], w_fill};
  assign w_ovfNext   = r_ovf | (w_msb & ~r_mode);
  assign w_lastShift = (r_cnt == SHAMT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (start) w_stateNext = (amt == '0) ? DONE : SHIFT;
      SHIFT:   if (w_lastShift) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // The carry accumulator is not kept separately: the last bit out is simply the MSB
  // leaving on the final shift, so it is captured straight into r_carry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_work     <= '0;
      r_cnt      <= '0;
      r_mode     <= 1'b0;
      r_ovf      <= 1'b0;
      r_out      <= '0;
      r_overflow <= 1'b0;
      r_carry    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_work <= in;
            r_cnt  <= amt;
            r_mode <= mode;
            r_ovf  <= 1'b0;
            if (amt == '0) begin
              r_out      <= in;
              r_overflow <= 1'b0;
              r_carry    <= 1'b0;
            end
          end
        end
        SHIFT: begin
          r_work <= w_workNext;
          r_ovf  <= w_ovfNext;
          r_cnt  <= r_cnt - SHAMT_W'(1);
          if (w_lastShift) begin
            r_out      <= w_workNext;
            r_overflow <= w_ovfNext;
            r_carry    <= w_msb;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = (r_state == IDLE);
  assign done      = (r_state == DONE);
  assign out       = r_out;
  assign overflow  = r_overflow;
  assign carry_out = r_carry;

endmodule

// File: tb/tb_left_shift_sequencer.sv
// Directed scoreboard bench for left_shift_sequencer: expectations come from a
// closed-form shift/rotate model and are checked with immediate assertions.
module tb_left_shift_sequencer;

  localparam int W = 16;
  localparam int S = 5;

  typedef struct {
    logic [W-1:0] out;
    logic         ovf;
    logic         cy;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         mode;
  logic [W-1:0] in;
  logic [S-1:0] amt;
  logic         ready;
  logic         done;
  logic [W-1:0] out;
  logic         overflow;
  logic         carry_out;

  int           total = 0;
  int           bad = 0;
  exp_t         sb[$];
  logic [W-1:0] prevOut;

  left_shift_sequencer #(.WIDTH(W), .SHAMT_W(S)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .in(in), .amt(amt),
    .ready(ready), .done(done), .out(out), .overflow(overflow), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Closed-form reference: logical shift drops bits off the top, rotate wraps mod W.
  function automatic exp_t model(input logic m, input logic [W-1:0] x, input int n);
    exp_t e;
    int   r;
    e.lat = n;
    e.ovf = 1'b0;
    e.cy  = 1'b0;
    if (!m) begin
      e.out = (n >= W) ? '0 : W'(x << n);
      if (n > 0 && n <= W) begin
        e.ovf = ((x >> (W - n)) != '0);
        e.cy  = x[W-n];
      end else if (n > W) begin
        e.ovf = (x != '0);
      end
    end else begin
      r     = n % W;
      e.out = (r == 0) ? x : W'((x << r) | (x >> (W - r)));
      e.cy  = (n == 0) ? 1'b0 : e.out[0];
    end
    return e;
  endfunction

  task automatic doCheck(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Waits for ready, presents one request, and scrambles the inputs after the accept edge.
  task automatic applyStimulus(input logic m, input logic [W-1:0] x, input int n,
                               input bit expectResult);
    int waited = 0;
    @(negedge clk);
    while (!ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    doCheck("ready_before_start", 32'(ready), 32'd1);
    mode  = m;
    in    = x;
    amt   = S'(n);
    start = 1'b1;
    if (expectResult) sb.push_back(model(m, x, n));
    @(posedge clk);
    #1;
    start = 1'b0;
    in    = ~x;
    amt   = ~S'(n);
    mode  = ~m;
  endtask

  // Called just after an accept edge; checks latency, held output, result and pulse width.
  task automatic checkOutput();
    exp_t e;
    int   lat = 0;
    if (sb.size() == 0) begin
      doCheck("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    forever begin
      @(negedge clk);
      if (done || lat > 100) break;
      doCheck("out_held", 32'(out), 32'(prevOut));
      lat++;
    end
    doCheck("latency", 32'(lat), 32'(e.lat));
    doCheck("out", 32'(out), 32'(e.out));
    doCheck("overflow", 32'(overflow), 32'(e.ovf));
    doCheck("carry_out", 32'(carry_out), 32'(e.cy));
    doCheck("ready_in_done", 32'(ready), 32'd0);
    prevOut = e.out;
    @(negedge clk);
    doCheck("done_one_cycle", 32'(done), 32'd0);
    doCheck("ready_after_done", 32'(ready), 32'd1);
  endtask

  initial begin
    exp_t e;
    int   seen;
    reset_n = 1'b0;
    start   = 1'b0;
    mode    = 1'b0;
    in      = '0;
    amt     = '0;
    prevOut = '0;
    repeat (2) @(negedge clk);
    doCheck("rst_out", 32'(out), 32'd0);
    doCheck("rst_done", 32'(done), 32'd0);
    doCheck("rst_ready", 32'(ready), 32'd1);
    doCheck("rst_ovf", 32'(overflow), 32'd0);
    doCheck("rst_cy", 32'(carry_out), 32'd0);
    reset_n = 1'b1;

    $display("[TB] logical shift");
    applyStimulus(1'b0, 16'h00F0, 4, 1'b1);
    checkOutput();

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 16'h1234, 10, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    doCheck("abort_out", 32'(out), 32'd0);
    doCheck("abort_done", 32'(done), 32'd0);
    doCheck("abort_ready", 32'(ready), 32'd1);
    doCheck("abort_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    prevOut = '0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    doCheck("abort_no_done", 32'(seen), 32'd0);
    doCheck("abort_ready_after", 32'(ready), 32'd1);
    doCheck("abort_out_after", 32'(out), 32'd0);

    $display("[TB] logical overflow");
    applyStimulus(1'b0, 16'h8001, 1, 1'b1);
    checkOutput();
    applyStimulus(1'b0, 16'hFFFF, 20, 1'b1);
    checkOutput();

    $display("[TB] rotate");
    applyStimulus(1'b1, 16'h8001, 4, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 16'h0001, 17, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 16'hC3A5, 31, 1'b1);
    checkOutput();

    $display("[TB] zero amount with start while busy");
    applyStimulus(1'b0, 16'hABCD, 0, 1'b1);
    e = sb.pop_front();
    @(negedge clk);
    doCheck("zero_done", 32'(done), 32'd1);
    doCheck("zero_ready", 32'(ready), 32'd0);
    doCheck("zero_out", 32'(out), 32'(e.out));
    doCheck("zero_ovf", 32'(overflow), 32'(e.ovf));
    doCheck("zero_cy", 32'(carry_out), 32'(e.cy));
    start = 1'b1;
    in    = 16'h0003;
    amt   = 5'd2;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    doCheck("busy_ready", 32'(ready), 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen++;
    end
    doCheck("busy_ignored", 32'(seen), 32'd0);
    doCheck("busy_out_kept", 32'(out), 32'hABCD);
    prevOut = 16'hABCD;

    $display("[TB] back-to-back");
    @(negedge clk);
    mode  = 1'b0;
    amt   = 5'd3;
    in    = 16'h0011;
    start = 1'b1;
    sb.push_back(model(1'b0, 16'h0011, 3));
    @(posedge clk);
    #1;
    in = 16'h1003;
    sb.push_back(model(1'b0, 16'h1003, 3));
    checkOutput();
    @(posedge clk);
    #1;
    in = 16'h8000;
    sb.push_back(model(1'b0, 16'h8000, 3));
    checkOutput();
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput();
    doCheck("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
